// File: rtl/sync_memory_unit_if.sv
// Request/response bundle for sync_memory_unit. The parity strap and error strobe
// exist only when PARITY_EN is defined.
interface sync_memory_unit_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
);
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic              op;
  logic              select;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] in_bus;
  logic              clear;
  logic [DATA_W-1:0] out_bus;
  logic              out_valid;
  logic              busy;
`ifdef PARITY_EN
  logic              inj_par;
  logic              parity_err;
`endif

  modport master (
    output op, select, address, in_bus, clear,
`ifdef PARITY_EN
    output inj_par,
    input  parity_err,
`endif
    input  out_bus, out_valid, busy
  );

  modport slave (
    input  op, select, address, in_bus, clear,
`ifdef PARITY_EN
    input  inj_par,
    output parity_err,
`endif
    output out_bus, out_valid, busy
  );
endinterface

// File: rtl/sync_memory_unit.sv
// DEPTH x DATA_W flop-array memory with registered reads and a zero-fill sweep that runs
// after reset or on clear. Define PARITY_EN to add a per-word even-parity bit.
module sync_memory_unit #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  sync_memory_unit_if.slave  bus
);
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] word_t;
  typedef enum logic [0:0] {ST_CLEAR, ST_IDLE} state_t;

  localparam addr_t           LAST_ADDR = addr_t'(DEPTH - 1);
  localparam logic [ADDR_W:0] DEPTH_V   = (ADDR_W + 1)'(DEPTH);

  state_t state, state_nxt;
  addr_t  clr_ptr;
  word_t  mem [DEPTH];
  logic   sweep_we;
  logic   addr_ok;
  logic   wr_en;
  logic   rd_en;
`ifdef PARITY_EN
  logic   par_mem [DEPTH];
`endif

  // State register plus the sweep pointer it sequences.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_CLEAR)
        clr_ptr <= (clr_ptr == LAST_ADDR) ? '0 : clr_ptr + 1'b1;
      else if (bus.clear)
        clr_ptr <= '0;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_CLEAR: if (clr_ptr == LAST_ADDR) state_nxt = ST_IDLE;
      ST_IDLE:  if (bus.clear)            state_nxt = ST_CLEAR;
      default:                            state_nxt = ST_CLEAR;
    endcase
  end

  // Outputs and strobes; clear wins over a same-cycle request.
  always_comb begin
    bus.busy = 1'b0;
    sweep_we = 1'b0;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    addr_ok  = ({1'b0, bus.address} < DEPTH_V);
    if (state == ST_CLEAR) begin
      bus.busy = 1'b1;
      sweep_we = 1'b1;
    end else if (!bus.clear && bus.select) begin
      wr_en = bus.op && addr_ok;
      rd_en = !bus.op;
    end
  end

  // NOTE: the storage array has no reset; zeroing is the sweep's job, which keeps it a plain flop array.
  always_ff @(posedge clk) begin
    if (sweep_we)
      mem[clr_ptr] <= '0;
    else if (wr_en)
      mem[bus.address] <= bus.in_bus;
  end

`ifdef PARITY_EN
  always_ff @(posedge clk) begin
    if (sweep_we)
      par_mem[clr_ptr] <= 1'b0;
    else if (wr_en)
      par_mem[bus.address] <= (^bus.in_bus) ^ bus.inj_par;
  end
`endif

  // Registered read port; out-of-range reads return zero but still strobe valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_bus    <= '0;
      bus.out_valid  <= 1'b0;
`ifdef PARITY_EN
      bus.parity_err <= 1'b0;
`endif
    end else begin
      bus.out_valid <= rd_en;
      if (rd_en)
        bus.out_bus <= addr_ok ? mem[bus.address] : '0;
`ifdef PARITY_EN
      bus.parity_err <= rd_en && addr_ok && (par_mem[bus.address] != (^mem[bus.address]));
`endif
    end
  end
endmodule

// File: tb/tb_sync_memory_unit.sv
// Scoreboard bench for sync_memory_unit: a DEPTH=8 instance for the main behaviour and a
// DEPTH=6 instance for out-of-range addressing. Parity checks appear when PARITY_EN is defined.
module tb_sync_memory_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sync_memory_unit_if #(.DATA_W(8), .DEPTH(8)) bus  ();
  sync_memory_unit_if #(.DATA_W(8), .DEPTH(6)) bus6 ();

  sync_memory_unit #(.DATA_W(8), .DEPTH(8)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  sync_memory_unit #(.DATA_W(8), .DEPTH(6)) dut6 (.clk(clk), .rst_n(rst_n), .bus(bus6));

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
  } exp_t;

  exp_t q  [$];
  exp_t q6 [$];
  exp_t e_m, e_m6;
  int   checks = 0;
  int   errors = 0;
  int   n8, n6;

  logic [7:0] model  [8];
  logic       par_m  [8];
  logic [7:0] model6 [8];
  logic       par_m6 [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.select = 0; bus.op = 0; bus.clear = 0; bus.address = '0; bus.in_bus = '0;
    bus6.select = 0; bus6.op = 0; bus6.clear = 0; bus6.address = '0; bus6.in_bus = '0;
`ifdef PARITY_EN
    bus.inj_par = 0;
    bus6.inj_par = 0;
`endif
  endtask

  task automatic model_zero();
    for (int i = 0; i < 8; i++) begin
      model[i] = '0; par_m[i] = 1'b0; model6[i] = '0; par_m6[i] = 1'b0;
    end
  endtask

  // Counts sampled busy cycles of both instances until both are idle (bounded).
  task automatic wait_sweep(output int c8, output int c6);
    int cyc;
    c8 = 0; c6 = 0; cyc = 0;
    while ((bus.busy || bus6.busy) && cyc < 50) begin
      if (bus.busy)  c8++;
      if (bus6.busy) c6++;
      cyc++;
      step();
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d, input logic inj);
    bus.select = 1; bus.op = 1; bus.address = a; bus.in_bus = d;
`ifdef PARITY_EN
    bus.inj_par = inj;
`endif
    model[a] = d;
    par_m[a] = (^d) ^ inj;
    step();
    bus.select = 0;
  endtask

  task automatic rd(input logic [2:0] a);
    exp_t e;
    e.data = model[a];
    e.perr = par_m[a] != (^model[a]);
    q.push_back(e);
    bus.select = 1; bus.op = 0; bus.address = a;
    step();
    bus.select = 0;
  endtask

  task automatic wr6(input logic [2:0] a, input logic [7:0] d);
    bus6.select = 1; bus6.op = 1; bus6.address = a; bus6.in_bus = d;
    if (a < 3'd6) begin
      model6[a] = d;
      par_m6[a] = ^d;
    end
    step();
    bus6.select = 0;
  endtask

  task automatic rd6(input logic [2:0] a);
    exp_t e;
    e.data = model6[a];
    e.perr = par_m6[a] != (^model6[a]);
    q6.push_back(e);
    bus6.select = 1; bus6.op = 0; bus6.address = a;
    step();
    bus6.select = 0;
  endtask

  always @(posedge clk) begin
    #1;
    if (bus.out_valid) begin
      if (q.size() == 0) check("spurious_valid", bus.out_valid, 1'b0);
      else begin
        e_m = q.pop_front();
        check("rd_data", bus.out_bus, e_m.data);
`ifdef PARITY_EN
        check("parity_err", bus.parity_err, e_m.perr);
`endif
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (bus6.out_valid) begin
      if (q6.size() == 0) check("spurious_valid6", bus6.out_valid, 1'b0);
      else begin
        e_m6 = q6.pop_front();
        check("rd_data6", bus6.out_bus, e_m6.data);
`ifdef PARITY_EN
        check("parity_err6", bus6.parity_err, e_m6.perr);
`endif
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    model_zero();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 1'b1);
    check("rst_valid", bus.out_valid, 1'b0);
    check("rst_out_bus", bus.out_bus, 8'h00);
    rst_n = 1;
    wait_sweep(n8, n6);
    check("init_sweep_len", n8, 8);
    check("init_sweep_len6", n6, 6);

    // All words read back as zero after the first sweep.
    for (int a = 0; a < 8; a++) rd(3'(a));

    // Write then immediate read, then hold with select low.
    wr(3'd0, 8'h55, 1'b0);
    rd(3'd0);
    repeat (2) begin
      step();
      check("hold_valid", bus.out_valid, 1'b0);
      check("hold_bus", bus.out_bus, 8'h55);
    end

    // Clear sweep drops a write, a read and a repeated clear issued during busy.
    wr(3'd4, 8'hF0, 1'b0);
    rd(3'd4);
    bus.clear = 1;
    step();
    bus.clear = 0;
    check("clear_busy", bus.busy, 1'b1);
    bus.select = 1; bus.op = 1; bus.address = 3'd4; bus.in_bus = 8'hAA; bus.clear = 1;
    step();
    bus.op = 0; bus.clear = 0;
    step();
    idle_inputs();
    wait_sweep(n8, n6);
    check("no_restart_len", n8, 6);
    model_zero();
    rd(3'd4);

    // Clear beats a same-cycle write and read request.
    wr(3'd2, 8'h33, 1'b0);
    bus.clear = 1; bus.select = 1; bus.op = 1; bus.address = 3'd2; bus.in_bus = 8'h11;
    step();
    idle_inputs();
    wait_sweep(n8, n6);
    check("clear_sweep_len", n8, 8);
    model_zero();
    rd(3'd2);
    bus.clear = 1; bus.select = 1; bus.op = 0; bus.address = 3'd2;
    step();
    idle_inputs();
    wait_sweep(n8, n6);
    check("clear_rd_sweep_len", n8, 8);

    // Reset in the middle of a sweep.
    wr(3'd6, 8'h5A, 1'b0);
    rd(3'd6);
    bus.clear = 1;
    step();
    bus.clear = 0;
    repeat (3) step();
    rst_n = 0;
    #1;
    check("midrst_busy", bus.busy, 1'b1);
    check("midrst_valid", bus.out_valid, 1'b0);
    check("midrst_out_bus", bus.out_bus, 8'h00);
    repeat (2) step();
    rst_n = 1;
    wait_sweep(n8, n6);
    check("rst_sweep_len", n8, 8);
    check("rst_sweep_len6", n6, 6);
    model_zero();
    for (int a = 0; a < 8; a++) rd(3'(a));

    // Random traffic against the model.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 1) wr(3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom_range(0, 1)));
      else                           rd(3'($urandom_range(0, 7)));
    end

`ifdef PARITY_EN
    wr(3'd3, 8'h01, 1'b1);
    rd(3'd3);
    wr(3'd3, 8'h01, 1'b0);
    rd(3'd3);
`endif

    // DEPTH=6: out-of-range write discarded, read returns zero with valid.
    wr6(3'd7, 8'h77);
    rd6(3'd7);
    wr6(3'd5, 8'h3C);
    rd6(3'd5);
    rd6(3'd6);
    for (int a = 0; a < 5; a++) rd6(3'(a));

    repeat (4) step();
    check("sb_drained", q.size(), 0);
    check("sb_drained6", q6.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
